// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch: prescaled up/down count, preset load,
// wrap-or-saturate limits and a lap-hold display freeze.
module bcd_stopwatch #(
    parameter int CLK_FREQ = 100000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 2,
    parameter int WRAP     = 1
) (
    input  logic                  clk,
    input  logic                  init_regs,
    input  logic                  count_enabled,
    input  logic                  count_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   time_reading,
    output logic                  tick,
    output logic                  wrap
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int W   = 4 * DIGITS;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic {
        LIVE,
        HELD
    } lap_state_e;

    lap_state_e    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  snap_q, snap_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  clamp_val;
    logic          carry;
    logic          borrow;
    logic          step;

    // Ripple carry/borrow out of the top digit flags the all-9s / all-0s limit.
    always_comb begin
        inc_val   = count_q;
        dec_val   = count_q;
        clamp_val = load_value;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_value[4*i +: 4] > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
            end
        end
    end

    assign step = count_enabled && (presc_q == PMAX);

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        snap_d  = snap_q;
        state_d = state_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = clamp_val;
            presc_d = '0;
            state_d = LIVE;
        end else begin
            if (count_enabled) begin
                presc_d = step ? '0 : presc_q + PW'(1);
            end
            if (step) begin
                tick_d = 1'b1;
                if (count_down) begin
                    wrap_d = borrow;
                    if (!borrow || WRAP != 0) begin
                        count_d = dec_val;
                    end
                end else begin
                    wrap_d = carry;
                    if (!carry || WRAP != 0) begin
                        count_d = inc_val;
                    end
                end
            end
            if (lap) begin
                unique case (state_q)
                    LIVE: begin
                        snap_d  = count_q;
                        state_d = HELD;
                    end
                    HELD: state_d = LIVE;
                    default: state_d = LIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge init_regs) begin
        if (init_regs) begin
            state_q <= LIVE;
            presc_q <= '0;
            count_q <= '0;
            snap_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign time_reading = (state_q == HELD) ? snap_q : count_q;
    assign tick         = tick_q;
    assign wrap         = wrap_q;

endmodule
